// File: rtl/sonar_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sonar_scheduler
// Brief    : Round-robin TRIG/ECHO scheduler for four ultrasonic sensors with a
//            shared echo-width counter, tagged results and per-sensor near flags.
// Revision : 1.0 - initial release
// ============================================================================
module sonar_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 50000,
    parameter int WIDTH          = 21
) (
    input  logic             SONAR_SCHEDULER_CLOCK_50,
    input  logic             SONAR_SCHEDULER_RESET_InHigh,
    input  logic [3:0]       SONAR_SCHEDULER_ENABLE_InBus,
    input  logic [WIDTH-1:0] SONAR_SCHEDULER_THRESHOLD_InBus,
    input  logic [3:0]       SONAR_SCHEDULER_ECHO_InBus,
    output logic [3:0]       SONAR_SCHEDULER_TRIG_OutBus,
    output logic [WIDTH-1:0] SONAR_SCHEDULER_RESULT_OutBus,
    output logic [1:0]       SONAR_SCHEDULER_RESULTID_OutBus,
    output logic             SONAR_SCHEDULER_RESULTVALID_Out,
    output logic             SONAR_SCHEDULER_TIMEOUT_Out,
    output logic [3:0]       SONAR_SCHEDULER_NEAR_OutBus,
    output logic             SONAR_SCHEDULER_BUSY_Out
);

    localparam int c_MAX_T1  = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
    localparam int c_MAX_T   = (TIMEOUT_CYCLES > c_MAX_T1) ? TIMEOUT_CYCLES : c_MAX_T1;
    localparam int c_TIMER_W = $clog2(c_MAX_T + 1);

    localparam logic [c_TIMER_W-1:0] c_TRIG_LAST    = c_TIMER_W'(TRIG_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_GUARD_LAST   = c_TIMER_W'(GUARD_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);
    localparam logic [WIDTH-1:0]     c_CNT_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_ALL_ONES     = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_GUARD     = 3'd4
    } state_t;

    wire clk = SONAR_SCHEDULER_CLOCK_50;
    wire rst = SONAR_SCHEDULER_RESET_InHigh;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_echo_meta;
    logic [3:0]           r_echo_sync;
    logic [c_TIMER_W-1:0] r_timer;
    logic [WIDTH-1:0]     r_counter;
    logic [1:0]           r_sel;
    logic [1:0]           r_ptr;
    logic [WIDTH-1:0]     r_result;
    logic [1:0]           r_result_id;
    logic                 r_valid;
    logic                 r_timeout;
    logic [3:0]           r_near;

    logic                 w_echo;
    logic [1:0]           w_next_sel;
    logic                 w_any;
    logic                 w_start;
    logic                 w_timer_clr;
    logic                 w_cnt_clr;
    logic                 w_cnt_load;
    logic                 w_cnt_inc;
    logic                 w_finish;
    logic                 w_finish_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_echo_meta <= '0;
            r_echo_sync <= '0;
        end else begin
            r_echo_meta <= SONAR_SCHEDULER_ECHO_InBus;
            r_echo_sync <= r_echo_meta;
        end
    end

    assign w_echo = r_echo_sync[r_sel];

    // Lowest cyclic offset after the pointer wins; the pointer itself is last.
    always_comb begin
        w_next_sel = r_ptr;
        w_any      = |SONAR_SCHEDULER_ENABLE_InBus;
        for (int k = 3; k >= 1; k--) begin
            if (SONAR_SCHEDULER_ENABLE_InBus[r_ptr + 2'(k)]) begin
                w_next_sel = r_ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_timer_clr  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_inc    = 1'b0;
        w_finish     = 1'b0;
        w_finish_to  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                if (w_any) begin
                    w_start      = 1'b1;
                    w_state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (r_timer == c_TRIG_LAST) begin
                    w_timer_clr  = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (w_echo) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_MEASURE;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_finish     = 1'b1;
                    w_finish_to  = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_GUARD;
                end
            end
            ST_MEASURE: begin
                // Echo fall is checked first so a fall on the last timer cycle is still a valid width.
                if (!w_echo) begin
                    w_finish     = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_GUARD;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_finish     = 1'b1;
                    w_finish_to  = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_GUARD;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_GUARD: begin
                if (r_timer == c_GUARD_LAST) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_timer_clr  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_counter   <= '0;
            r_sel       <= '0;
            r_ptr       <= 2'd3;
            r_result    <= '0;
            r_result_id <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_near      <= '0;
        end else begin
            if (w_timer_clr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TIMER_ONE;
            end

            if (w_start) begin
                r_sel <= w_next_sel;
            end

            if (w_cnt_clr) begin
                r_counter <= '0;
            end else if (w_cnt_load) begin
                r_counter <= c_CNT_ONE;
            end else if (w_cnt_inc && (r_counter != c_ALL_ONES)) begin
                r_counter <= r_counter + c_CNT_ONE;
            end

            r_valid <= w_finish;
            if (w_finish) begin
                r_result      <= w_finish_to ? c_ALL_ONES : r_counter;
                r_result_id   <= r_sel;
                r_timeout     <= w_finish_to;
                r_near[r_sel] <= !w_finish_to && (r_counter < SONAR_SCHEDULER_THRESHOLD_InBus);
                r_ptr         <= r_sel;
            end
        end
    end

    // Trigger decode straight from state so reset cuts a pulse immediately.
    for (genvar i = 0; i < 4; i++) begin : g_trig
        assign SONAR_SCHEDULER_TRIG_OutBus[i] = (r_state == ST_TRIG) && (r_sel == 2'(i));
    end

    assign SONAR_SCHEDULER_RESULT_OutBus   = r_result;
    assign SONAR_SCHEDULER_RESULTID_OutBus = r_result_id;
    assign SONAR_SCHEDULER_RESULTVALID_Out = r_valid;
    assign SONAR_SCHEDULER_TIMEOUT_Out     = r_timeout;
    assign SONAR_SCHEDULER_NEAR_OutBus     = r_near & SONAR_SCHEDULER_ENABLE_InBus;
    assign SONAR_SCHEDULER_BUSY_Out        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sonar_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_scheduler
// Brief    : Directed plus randomized bench for sonar_scheduler with a
//            behavioural scheduling/measurement model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_scheduler;

    localparam int TRIG  = 10;
    localparam int TO    = 1000;
    localparam int GUARD = 20;
    localparam int W     = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   enable = 4'hF;
    logic [W-1:0] threshold = 12'd300;
    logic [3:0]   echo = 4'h0;
    logic [3:0]   trig;
    logic [W-1:0] result;
    logic [1:0]   result_id;
    logic         result_valid;
    logic         timeout;
    logic [3:0]   near;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int ptr_m = 3;
    logic [3:0] near_m = 4'h0;

    sonar_scheduler #(
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TO),
        .GUARD_CYCLES  (GUARD),
        .WIDTH         (W)
    ) dut (
        .SONAR_SCHEDULER_CLOCK_50       (clk),
        .SONAR_SCHEDULER_RESET_InHigh   (rst),
        .SONAR_SCHEDULER_ENABLE_InBus   (enable),
        .SONAR_SCHEDULER_THRESHOLD_InBus(threshold),
        .SONAR_SCHEDULER_ECHO_InBus     (echo),
        .SONAR_SCHEDULER_TRIG_OutBus    (trig),
        .SONAR_SCHEDULER_RESULT_OutBus  (result),
        .SONAR_SCHEDULER_RESULTID_OutBus(result_id),
        .SONAR_SCHEDULER_RESULTVALID_Out(result_valid),
        .SONAR_SCHEDULER_TIMEOUT_Out    (timeout),
        .SONAR_SCHEDULER_NEAR_OutBus    (near),
        .SONAR_SCHEDULER_BUSY_Out       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_enabled(input int ptr, input logic [3:0] mask);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int s);
        logic [3:0] v;
        v = 4'h0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    // One scheduler firing: raw echo rises d clocks after trigger end and stays high n clocks.
    task automatic fire(input int d, input int n, input bit gap_chk,
                        input int mid_k, input logic [3:0] mid_mask, input bit noise);
        int s, w, k, vk, exp_vk;
        bit exp_to;
        logic [W-1:0] exp_res;
        logic [3:0] e;
        s = next_enabled(ptr_m, enable);
        w = 0;
        while (trig === 4'h0 && w < GUARD + 100) begin
            @(negedge clk);
            w++;
        end
        check("trig_sel", trig, onehot(s));
        if (s < 0) return;
        if (gap_chk) check("trig_gap", cyc - last_valid_cyc, GUARD + 1);
        w = 1;
        @(negedge clk);
        while (trig !== 4'h0 && w < 4 * TRIG) begin
            w++;
            @(negedge clk);
        end
        check("trig_width", w, TRIG);

        k  = 0;
        vk = -1;
        while (vk < 0 && k <= TO + 10) begin
            if (k == mid_k) enable = mid_mask;
            e = noise ? 4'($urandom) : 4'h0;
            e[s] = (k >= d) && (k < d + n);
            echo = e;
            if (result_valid === 1'b1) vk = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        echo = 4'h0;

        // Echo is seen 2 clocks late; its fall must be seen within the TO-clock window.
        if (d + n + 3 <= TO) begin
            exp_to = 1'b0;
            exp_vk = d + n + 3;
            exp_res = W'(n);
        end else begin
            exp_to = 1'b1;
            exp_vk = TO;
            exp_res = '1;
        end
        near_m[s] = !exp_to && (exp_res < threshold);
        ptr_m = s;
        last_valid_cyc = cyc;

        check("valid_time", vk, exp_vk);
        check("result", result, exp_res);
        check("result_id", result_id, s);
        check("timeout", timeout, exp_to);
        check("near", near, near_m & enable);
        check("busy_guard", busy, 1'b1);
        @(negedge clk);
        check("valid_pulse", result_valid, 1'b0);
        check("timeout_held", timeout, exp_to);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, s, d, n;
        repeat (3) @(negedge clk);
        check("reset_outs", {trig, result, result_id, result_valid, timeout, near, busy}, 0);
        rst = 1'b0;

        // Round-robin over all four sensors
        enable = 4'hF;
        threshold = 12'd300;
        fire(50, 200, 0, -1, 4'h0, 0);
        for (int i = 0; i < 4; i++) fire(50, 200, 1, -1, 4'h0, 0);
        check("rr_near", near, 4'hF);

        // Timeout: echo never rises
        enable = 4'b0100;
        fire(100000, 1, 1, -1, 4'h0, 0);
        check("to_near2", near[2], 1'b0);

        // Threshold boundary
        enable = 4'b0010;
        fire(5, 299, 1, -1, 4'h0, 0);
        check("thr_299", near[1], 1'b1);
        fire(5, 300, 1, -1, 4'h0, 0);
        check("thr_300", near[1], 1'b0);

        // Mask change while sensor 0 is measuring
        enable = 4'b0011;
        fire(20, 200, 1, 120, 4'b0010, 0);
        check("mask_near0", near[0], 1'b0);
        fire(20, 200, 1, -1, 4'h0, 0);
        fire(20, 100, 1, -1, 4'h0, 0);

        // Echo fall on the timeout cycle, then one clock later
        enable = 4'b0001;
        fire(10, TO - 13, 1, -1, 4'h0, 0);
        fire(10, TO - 12, 1, -1, 4'h0, 0);

        // Randomized firings with noise on unselected echo lines
        for (int i = 0; i < 12; i++) begin
            enable = 4'($urandom_range(1, 15));
            threshold = W'($urandom_range(50, 600));
            d = $urandom_range(0, 60);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(930, 1100) : $urandom_range(1, 400);
            fire(d, n, 1, $urandom_range(0, 300), 4'($urandom_range(1, 15)), 1);
        end

        // Empty mask keeps the scheduler idle
        enable = 4'h0;
        repeat (GUARD + 3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy !== 1'b0 || trig !== 4'h0) bad++;
            @(negedge clk);
        end
        check("mask0_idle", bad, 0);

        // Reset on trigger clock 5
        enable = 4'hF;
        s = next_enabled(ptr_m, enable);
        bad = 0;
        while (trig === 4'h0 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        repeat (4) @(negedge clk);
        check("trig_before_rst", trig, onehot(s));
        rst = 1'b1;
        #1;
        check("rst_async_outs", {trig, result, result_id, result_valid, timeout, near, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ptr_m = 3;
        near_m = 4'h0;
        fire(30, 150, 0, -1, 4'h0, 0);
        check("post_rst_id", result_id, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
